pipe_issue_ctrl: RTL and testbench

Issue controller in front of the 4-stage ALU pipeline (16x16 register bank, 256x16 data memory, 4-bit func).
- Buffers incoming instructions in a small FIFO.
- Issues at most one per cycle.
- Inserts bubbles on read-after-write hazards against in-flight destinations.
- Drops illegal opcodes and keeps issue/stall statistics.
- Sits between the instruction source and the pipeline's rs1/rs2/rd/func/addr inputs.

---
 rtl/pipe_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: FIFO-buffered instructions, one issue per cycle, RAW bubbles, illegal drop.
// Issue registered one edge after the head becomes visible; in_ready drops when full or flushing.
module pipe_issue_ctrl #(
  parameter int DEPTH    = 4,
  parameter int HAZ_WIN  = 2,
  parameter int NUM_FUNC = 12
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [7:0]  in_addr,
  input  logic        hold,
  input  logic        flush,
  output logic        iss_valid,
  output logic [3:0]  iss_func,
  output logic [3:0]  iss_rd,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [7:0]  iss_addr,
  output logic        err_illegal,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [4:0]  NUM_FUNC_W = 5'(NUM_FUNC);

  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  instr_t              mem_q [DEPTH];
  instr_t              mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [HAZ_WIN-1:0]  sb_vld_q, sb_vld_d;
  logic [3:0]          sb_rd_q [HAZ_WIN];
  logic [3:0]          sb_rd_d [HAZ_WIN];
  state_t              state_q, state_d;
  instr_t              iss_q, iss_d;
  logic                iss_valid_q, iss_valid_d;
  logic                err_q, err_d;
  logic [15:0]         issue_cnt_q, issue_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic   empty, full, push, advance, raw, hazard, head_legal;
  logic   do_pop, do_issue, do_drop, do_stall, last_pop;
  instr_t head, in_instr;

  assign in_instr   = '{func: in_func, rd: in_rd, rs1: in_rs1, rs2: in_rs2, addr: in_addr};
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNT_FULL);
  assign in_ready   = !full && !flush;
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign head_legal = ({1'b0, head.func} < NUM_FUNC_W);
  assign advance    = !flush && !hold;

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (sb_vld_q[i] && (head.rs1 == sb_rd_q[i] || head.rs2 == sb_rd_q[i])) raw = 1'b1;
    end
  end

  // Illegal heads neither stall nor enter the scoreboard.
  assign hazard   = !empty && head_legal && raw;
  assign do_pop   = advance && !empty && !hazard;
  assign do_issue = do_pop && head_legal;
  assign do_drop  = do_pop && !head_legal;
  assign do_stall = advance && hazard;
  assign last_pop = do_pop && (cnt_q == CNT_ONE) && !push;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    sb_vld_d    = sb_vld_q;
    sb_rd_d     = sb_rd_q;
    state_d     = state_q;
    iss_d       = iss_q;
    iss_valid_d = iss_valid_q;
    err_d       = do_drop;
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_instr;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    if (do_issue) begin
      iss_d       = head;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (do_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      sb_vld_d    = '0;
      iss_valid_d = 1'b0;
      state_d     = IDLE;
    end else if (!hold) begin
      iss_valid_d = do_issue;
      sb_vld_d[0] = do_issue;
      sb_rd_d[0]  = head.rd;
      for (int i = 1; i < HAZ_WIN; i++) begin
        sb_vld_d[i] = sb_vld_q[i-1];
        sb_rd_d[i]  = sb_rd_q[i-1];
      end
      case (state_q)
        IDLE:    if (!empty) state_d = RUN;
        RUN:     if (hazard) state_d = STALL;
                 else if (last_pop) state_d = IDLE;
        STALL:   if (!hazard) state_d = last_pop ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < HAZ_WIN; i++) sb_rd_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      sb_vld_q    <= '0;
      state_q     <= IDLE;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      sb_rd_q     <= sb_rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      sb_vld_q    <= sb_vld_d;
      state_q     <= state_d;
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
      err_q       <= err_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_func    = iss_q.func;
  assign iss_rd      = iss_q.rd;
  assign iss_rs1     = iss_q.rs1;
  assign iss_rs2     = iss_q.rs2;
  assign iss_addr    = iss_q.addr;
  assign err_illegal = err_q;
  assign busy        = !empty || (|sb_vld_q);
  assign issue_cnt   = issue_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: issue, RAW bubbles, illegal drop, hold, flush, counter limits.
module tb_pipe_issue_ctrl;
  logic        clk1 = 1'b0;
  logic        rst, in_valid, in_ready, hold, flush;
  logic [3:0]  in_func, in_rd, in_rs1, in_rs2;
  logic [7:0]  in_addr;
  logic        iss_valid, err_illegal, busy;
  logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
  logic [7:0]  iss_addr;
  logic [15:0] issue_cnt, stall_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_issue_ctrl dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_addr(in_addr),
    .hold(hold), .flush(flush), .iss_valid(iss_valid), .iss_func(iss_func), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_addr(iss_addr), .err_illegal(err_illegal),
    .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] f, input logic [3:0] rd,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [7:0] a);
    in_valid = v; in_func = f; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_addr = a;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  16'(in_ready), 16'd1);
    check("rst_iss_valid", 16'(iss_valid), 16'd0);
    check("rst_iss_rd",    16'(iss_rd), 16'd0);
    check("rst_iss_addr",  16'(iss_addr), 16'd0);
    check("rst_err",       16'(err_illegal), 16'd0);
    check("rst_busy",      16'(busy), 16'd0);
    check("rst_issue_cnt", issue_cnt, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);

    // back-to-back independent instructions
    set_in(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h10); tick();
    set_in(1'b1, 4'd6, 4'd4, 4'd5, 4'd6, 8'h20); tick();
    check("t1_add_vld", 16'(iss_valid), 16'd1);
    check("t1_add_rd",  16'(iss_rd), 16'd3);
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t1_or_vld",  16'(iss_valid), 16'd1);
    check("t1_or_func", 16'(iss_func), 16'd6);
    check("t1_or_addr", 16'(iss_addr), 16'h20);
    tick(); tick();
    check("t1_issue_cnt", issue_cnt, 16'd2);
    check("t1_stall_cnt", stall_cnt, 16'd0);
    check("t1_busy",      16'(busy), 16'd0);

    // RAW: two bubbles
    set_in(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h30); tick();
    set_in(1'b1, 4'd1, 4'd4, 4'd3, 4'd3, 8'h31); tick();
    check("t2a_p_vld", 16'(iss_valid), 16'd1);
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t2a_b1_vld",  16'(iss_valid), 16'd0);
    check("t2a_b1_rd",   16'(iss_rd), 16'd3);
    check("t2a_b1_stall", stall_cnt, 16'd1);
    tick();
    check("t2a_b2_vld",   16'(iss_valid), 16'd0);
    check("t2a_b2_stall", stall_cnt, 16'd2);
    tick();
    check("t2a_d_vld",  16'(iss_valid), 16'd1);
    check("t2a_d_rd",   16'(iss_rd), 16'd4);
    check("t2a_d_func", 16'(iss_func), 16'd1);
    tick(); tick(); tick();

    // RAW with one independent instruction between: one bubble
    set_in(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h32); tick();
    set_in(1'b1, 4'd2, 4'd5, 4'd6, 4'd7, 8'h33); tick();
    check("t2b_p_rd", 16'(iss_rd), 16'd3);
    set_in(1'b1, 4'd1, 4'd4, 4'd3, 4'd3, 8'h34); tick();
    check("t2b_i_vld", 16'(iss_valid), 16'd1);
    check("t2b_i_rd",  16'(iss_rd), 16'd5);
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t2b_bub_vld", 16'(iss_valid), 16'd0);
    check("t2b_stall",   stall_cnt, 16'd3);
    tick();
    check("t2b_d_vld", 16'(iss_valid), 16'd1);
    check("t2b_d_rd",  16'(iss_rd), 16'd4);
    check("t2b_issue_cnt", issue_cnt, 16'd7);
    check("t2b_stall_end", stall_cnt, 16'd3);

    // illegal opcode dropped; its rd must not block the next instruction
    rst = 1'b1; tick(); rst = 1'b0;
    set_in(1'b1, 4'd13, 4'd9, 4'd3, 4'd3, 8'h40); tick();
    set_in(1'b1, 4'd0,  4'd7, 4'd9, 4'd9, 8'h41); tick();
    check("t3_drop_vld", 16'(iss_valid), 16'd0);
    check("t3_err",      16'(err_illegal), 16'd1);
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t3_err_clr",  16'(err_illegal), 16'd0);
    check("t3_add_vld",  16'(iss_valid), 16'd1);
    check("t3_add_rd",   16'(iss_rd), 16'd7);
    check("t3_add_addr", 16'(iss_addr), 16'h41);
    check("t3_issue_cnt", issue_cnt, 16'd1);
    check("t3_stall_cnt", stall_cnt, 16'd0);
    tick(); tick(); tick();

    // fill under hold, then drain at one per cycle
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 4'd3, 4'(8 + i), 4'd0, 4'd1, 8'(8'h50 + i)); tick();
      check("t4_fill_ready", 16'(in_ready), (i < 3) ? 16'd1 : 16'd0);
      check("t4_fill_vld",   16'(iss_valid), 16'd0);
    end
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
    check("t4_busy", 16'(busy), 16'd1);
    check("t4_hold_cnt", issue_cnt, 16'd1);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_drain_vld",   16'(iss_valid), 16'd1);
      check("t4_drain_rd",    16'(iss_rd), 16'(8 + i));
      check("t4_drain_ready", 16'(in_ready), 16'd1);
    end
    check("t4_issue_cnt", issue_cnt, 16'd5);
    tick(); tick(); tick();

    // flush in the middle of a stall, with a refused push
    set_in(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h60); tick();
    set_in(1'b1, 4'd1, 4'd4, 4'd3, 4'd0, 8'h61); tick();
    check("t5_p_vld", 16'(iss_valid), 16'd1);
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t5_bub_vld", 16'(iss_valid), 16'd0);
    check("t5_bub_stall", stall_cnt, 16'd1);
    flush = 1'b1;
    set_in(1'b1, 4'd0, 4'd12, 4'd0, 4'd0, 8'h62);
    #1;
    check("t5_flush_ready", 16'(in_ready), 16'd0);
    tick();
    flush = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00);
    check("t5_busy",  16'(busy), 16'd0);
    check("t5_vld",   16'(iss_valid), 16'd0);
    check("t5_issue_cnt", issue_cnt, 16'd6);
    check("t5_stall_cnt", stall_cnt, 16'd1);
    tick();
    check("t5_after_vld",  16'(iss_valid), 16'd0);
    check("t5_after_busy", 16'(busy), 16'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_rst_issue", issue_cnt, 16'd0);
    check("t5_rst_stall", stall_cnt, 16'd0);

    // saturation of stall_cnt and wrap of issue_cnt
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    set_in(1'b1, 4'd0, 4'd3, 4'd1, 4'd2, 8'h70); tick();
    set_in(1'b1, 4'd1, 4'd3, 4'd3, 4'd3, 8'h71); tick();
    check("t6_p_vld", 16'(iss_valid), 16'd1);
    hold = 1'b1;
    set_in(1'b1, 4'd2, 4'd3, 4'd3, 4'd3, 8'h72); tick();
    check("t6_hold_vld",   16'(iss_valid), 16'd1);
    check("t6_hold_func",  16'(iss_func), 16'd0);
    check("t6_hold_stall", stall_cnt, 16'hFFFD);
    hold = 1'b0;
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t6_b1_vld",   16'(iss_valid), 16'd0);
    check("t6_b1_stall", stall_cnt, 16'hFFFE);
    tick();
    check("t6_b2_stall", stall_cnt, 16'hFFFF);
    tick();
    check("t6_d1_vld",  16'(iss_valid), 16'd1);
    check("t6_d1_func", 16'(iss_func), 16'd1);
    tick();
    check("t6_b3_vld",   16'(iss_valid), 16'd0);
    check("t6_b3_stall", stall_cnt, 16'hFFFF);
    tick();
    check("t6_b4_stall", stall_cnt, 16'hFFFF);
    tick();
    check("t6_d2_vld",  16'(iss_valid), 16'd1);
    check("t6_d2_func", 16'(iss_func), 16'd2);
    check("t6_issue_cnt", issue_cnt, 16'd3);
    force dut.issue_cnt_q = 16'hFFFF;
    #1;
    release dut.issue_cnt_q;
    set_in(1'b1, 4'd4, 4'd13, 4'd0, 4'd0, 8'h80); tick();
    set_in(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00); tick();
    check("t6_wrap_vld", 16'(iss_valid), 16'd1);
    check("t6_wrap_rd",  16'(iss_rd), 16'd13);
    check("t6_wrap_cnt", issue_cnt, 16'd0);
    check("t6_sat_keep", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
